display_scan: RTL
=================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clock cycles each digit is lit per slot (legal range 1 or more).
REQ-002 SHALL have parameter GAP, default 500, meaning blanking cycles between digit slots (legal range 1 or more).
REQ-003 SHALL have port clk  input  1  rising-edge system clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port seg_tens  input  7  tens-digit segment pattern, active-low, bit6..bit0 = g..a, from the BCD display decoder.
REQ-006 SHALL have port seg_ones  input  7  ones-digit segment pattern, same encoding as seg_tens.
REQ-007 SHALL have port load  input  1  strobe: capture seg_tens/seg_ones this cycle.
REQ-008 SHALL have port seg  output  7  shared active-low segment bus to the multiplexed display.
REQ-009 SHALL have port an  output  2  active-low digit enables, an[0]=ones, an[1]=tens.
REQ-010 SHALL have port frame  output  1  one-cycle pulse marking the end of each complete refresh frame.

Function
REQ-011 SHALL hold a shadow register pair (sh_tens, sh_ones), written from seg_tens/seg_ones on any clock edge with load=1.
REQ-012 SHALL hold an active register pair (ac_tens, ac_ones), updated from the shadow pair only on the GAP0->SHOW_ONES transition; both digits always update together.
REQ-013 SHALL, on load=1 in the same cycle as GAP0->SHOW_ONES, copy the pre-load shadow values to the active pair; new values appear in the following frame.
REQ-014 SHALL pass input patterns unmodified, including non-digit codes; no decoding or validity checks.
REQ-015 SHALL implement a 4-state FSM: SHOW_ONES -> GAP1 -> SHOW_TENS -> GAP0 -> SHOW_ONES.
REQ-016 SHALL keep each SHOW state for exactly DIV cycles and each GAP state for exactly GAP cycles, using one down/up counter cleared on every state transition; frame length is 2*(DIV+GAP) cycles.
REQ-017 SHALL size the counter for max(DIV,GAP)-1 with no wrap before the terminal count.
REQ-018 SHALL decode outputs from registered state and active registers only, with no dependency on seg_tens, seg_ones or load in the same cycle.
REQ-019 SHALL in SHOW_ONES drive an=2'b10, seg=ac_ones.
REQ-020 SHALL in SHOW_TENS drive an=2'b01, seg=ac_tens.
REQ-021 SHALL in GAP0/GAP1 drive an=2'b11, seg=7'b1111111.
REQ-022 SHALL never assert both an bits low in any cycle.
REQ-023 SHALL assert frame=1 only during the last cycle of GAP0, and deassert it otherwise.

Reset
REQ-024 SHALL, while rst_n=0, force state=SHOW_ONES, counter=0, shadow and active pairs=7'b1111111, and frame=0, independent of clk.
REQ-025 SHALL, as a result of REQ-024, show blank segments for the whole first frame after reset (an=2'b10, seg=7'b1111111 in SHOW_ONES).
REQ-026 SHALL, when rst_n is asserted mid-frame, abort the frame immediately; the first frame after release starts at SHOW_ONES count 0.

Configuration
REQ-027 SHALL, with macro DISPLAY_SCAN_LZB_EN defined, blank the tens digit when ac_tens==7'b1000000 (an=2'b11, seg=7'b1111111 during SHOW_TENS), leaving FSM timing and frame unchanged.
REQ-028 SHALL, without DISPLAY_SCAN_LZB_EN, display the tens digit in SHOW_TENS for every pattern, including zero.

Verification (DIV=4, GAP=2, 12-cycle frame)
REQ-029 SHALL test reset release followed by 12 cycles with load=0: an follows 10x4, 11x2, 01x4, 11x2; seg=7'b1111111 throughout; frame pulses once at cycle 11.
REQ-030 SHALL test load with tens=7'b1111001 ("1") and ones=7'b0100100 ("2") during frame 0: frame 1 shows seg=0100100 with an=10 and seg=1111001 with an=01.
REQ-031 SHALL test load on the cycle of the GAP0->SHOW_ONES transition: the next frame shows the previous values and the frame after shows the new values.
REQ-032 SHALL test rst_n pulsed low at cycle 7 (mid SHOW_TENS): outputs go to an=10, seg=7'b1111111 asynchronously; the active pair is blank and frame restarts at count 0 after release.
REQ-033 SHALL test tens=7'b1000000 and ones=7'b0010010 loaded: with DISPLAY_SCAN_LZB_EN, an=11 during SHOW_TENS; without it, an=01 and seg=1000000.
REQ-034 SHALL test all cycles of 50 random-load frames: an!=2'b00, and seg=7'b1111111 whenever an=2'b11.

Source files
------------

// File: rtl/display_scan.sv
// Two-digit multiplexed 7-segment scanner with shadow/active pattern buffering.
// Optional leading-zero blanking of the tens digit: define DISPLAY_SCAN_LZB_EN.
module display_scan #(
   parameter int DIV = 50000,
   parameter int GAP = 500
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg_tens,
   input  logic [6:0] seg_ones,
   input  logic       load,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       frame
);

   localparam int MAXC = (DIV > GAP) ? DIV : GAP;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
   localparam logic [6:0]    BLANK    = 7'b1111111;

   typedef enum logic [1:0] {
      SHOW_ONES = 2'd0,
      GAP1      = 2'd1,
      SHOW_TENS = 2'd2,
      GAP0      = 2'd3
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [6:0]    sh_tens_reg, sh_ones_reg;
   logic [6:0]    ac_tens_reg, ac_ones_reg;
   logic          last_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= SHOW_ONES;
         cnt_reg     <= '0;
         sh_tens_reg <= BLANK;
         sh_ones_reg <= BLANK;
         ac_tens_reg <= BLANK;
         ac_ones_reg <= BLANK;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (load) begin
            sh_tens_reg <= seg_tens;
            sh_ones_reg <= seg_ones;
         end
         // Active pair takes the pre-load shadow value at the frame boundary.
         if (state_reg == GAP0 && last_cnt) begin
            ac_tens_reg <= sh_tens_reg;
            ac_ones_reg <= sh_ones_reg;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + CW'(1);
      if (state_reg == SHOW_ONES || state_reg == SHOW_TENS)
         last_cnt = (cnt_reg == DIV_LAST);
      else
         last_cnt = (cnt_reg == GAP_LAST);
      if (last_cnt) begin
         cnt_next = '0;
         case (state_reg)
            SHOW_ONES: state_next = GAP1;
            GAP1:      state_next = SHOW_TENS;
            SHOW_TENS: state_next = GAP0;
            default:   state_next = SHOW_ONES;
         endcase
      end
   end

   always_comb begin
      an    = 2'b11;
      seg   = BLANK;
      frame = (state_reg == GAP0) && (cnt_reg == GAP_LAST);
      case (state_reg)
         SHOW_ONES: begin
            an  = 2'b10;
            seg = ac_ones_reg;
         end
         SHOW_TENS: begin
`ifdef DISPLAY_SCAN_LZB_EN
            if (ac_tens_reg != 7'b1000000) begin
               an  = 2'b01;
               seg = ac_tens_reg;
            end
`else
            an  = 2'b01;
            seg = ac_tens_reg;
`endif
         end
         default: begin
            an  = 2'b11;
            seg = BLANK;
         end
      endcase
   end

endmodule
